// File: rtl/alarm_ring_sched.sv
// Alarm event sequencer: detects the alarm minute, then runs ring / snooze / dismiss and drives the LED blink.
// Optional macro ALARM_TIMEOUT_EN adds auto-dismiss after RING_TIMEOUT seconds of continuous ringing.
module alarm_ring_sched #(
  parameter int SNOOZE_SEC = 300,
  parameter int MAX_SNOOZE = 3
`ifdef ALARM_TIMEOUT_EN
  ,
  parameter int RING_TIMEOUT = 60
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic [3:0] HT,
  input  logic [3:0] HU,
  input  logic [3:0] MT,
  input  logic [3:0] MU,
  input  logic [3:0] HT_al,
  input  logic [3:0] HU_al,
  input  logic [3:0] MT_al,
  input  logic [3:0] MU_al,
  input  logic       arm,
  input  logic       snooze,
  input  logic       stop,
  output logic       ring_led,
  output logic       ringing,
  output logic       snoozing,
  output logic [3:0] snooze_cnt,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RING   = 3'd1,
    S_SNOOZE = 3'd2,
    S_DONE   = 3'd3
  } state_t;

  localparam logic [9:0] SNOOZE_LAST = 10'(SNOOZE_SEC - 1);
  localparam logic [3:0] MAX_CNT     = 4'(MAX_SNOOZE);
`ifdef ALARM_TIMEOUT_EN
  localparam logic [9:0] RING_LAST   = 10'(RING_TIMEOUT - 1);
`endif

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_match_d;
  logic        r_rise;
  logic [15:0] r_al;
  logic [9:0]  r_sec;
  logic [9:0]  w_sec_nxt;
  logic [9:0]  w_sec_inc;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_nxt;
  logic        r_blink;
  logic        w_blink_nxt;
  logic [15:0] w_al;
  logic [15:0] w_time;
  logic        w_match;
  logic        w_force;

  assign w_al      = {HT_al, HU_al, MT_al, MU_al};
  assign w_time    = {HT, HU, MT, MU};
  // An alarm of 00:00 means the alarm is disabled.
  assign w_match   = arm && (w_time == w_al) && (w_al != 16'h0000);
  assign w_force   = !arm || (w_al != r_al);
  assign w_sec_inc = (r_sec == 10'h3FF) ? r_sec : r_sec + 10'd1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_match_d <= 1'b0;
      r_rise    <= 1'b0;
      r_al      <= 16'h0000;
      r_sec     <= 10'd0;
      r_cnt     <= 4'd0;
      r_blink   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_match_d <= w_match;
      r_rise    <= w_match && !r_match_d;
      r_al      <= w_al;
      r_sec     <= w_sec_nxt;
      r_cnt     <= w_cnt_nxt;
      r_blink   <= w_blink_nxt;
    end
  end

  // A button taken in the same cycle as a tick consumes that tick.
  always_comb begin
    w_state_nxt = r_state;
    w_sec_nxt   = r_sec;
    w_cnt_nxt   = r_cnt;
    w_blink_nxt = r_blink;
    if (w_force) begin
      w_state_nxt = S_IDLE;
      w_sec_nxt   = 10'd0;
      w_cnt_nxt   = 4'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_rise) begin
            w_state_nxt = S_RING;
            w_sec_nxt   = 10'd0;
            w_cnt_nxt   = 4'd0;
            w_blink_nxt = 1'b1;
          end
        end
        S_RING: begin
          if (stop) begin
            w_state_nxt = S_DONE;
          end else if (snooze) begin
            if (r_cnt < MAX_CNT) begin
              w_state_nxt = S_SNOOZE;
              w_cnt_nxt   = r_cnt + 4'd1;
              w_sec_nxt   = 10'd0;
            end else begin
              w_state_nxt = S_DONE;
            end
          end else if (tick_1hz) begin
            w_blink_nxt = !r_blink;
`ifdef ALARM_TIMEOUT_EN
            if (r_sec == RING_LAST) begin
              w_state_nxt = S_DONE;
            end else begin
              w_sec_nxt = w_sec_inc;
            end
`endif
          end
        end
        S_SNOOZE: begin
          if (stop) begin
            w_state_nxt = S_DONE;
          end else if (tick_1hz) begin
            if (r_sec == SNOOZE_LAST) begin
              w_state_nxt = S_RING;
              w_sec_nxt   = 10'd0;
              w_blink_nxt = 1'b1;
            end else begin
              w_sec_nxt = w_sec_inc;
            end
          end
        end
        S_DONE: begin
          if (!w_match) begin
            w_state_nxt = S_IDLE;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  assign ringing    = (r_state == S_RING);
  assign snoozing   = (r_state == S_SNOOZE);
  assign ring_led   = ringing && r_blink;
  assign snooze_cnt = r_cnt;
  assign state      = r_state;

endmodule

// File: tb/tb_alarm_ring_sched.sv
// Directed bench for alarm_ring_sched: each expected output vector is queued as stimulus is issued
// and popped by an independent negedge monitor.
module tb_alarm_ring_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick_1hz = 1'b0;
  logic [3:0] HT = 4'd0, HU = 4'd0, MT = 4'd0, MU = 4'd0;
  logic [3:0] HT_al = 4'd0, HU_al = 4'd0, MT_al = 4'd0, MU_al = 4'd0;
  logic       arm = 1'b0;
  logic       snooze = 1'b0;
  logic       stop = 1'b0;
  logic       ring_led;
  logic       ringing;
  logic       snoozing;
  logic [3:0] snooze_cnt;
  logic [2:0] state;

  // Vector layout: {state[2:0], ringing, snoozing, ring_led, snooze_cnt[3:0]}
  logic [9:0] exp_q[$];
  string      name_q[$];
  int         n_cmp = 0;
  int         n_fail = 0;

  alarm_ring_sched #(
    .SNOOZE_SEC(5),
    .MAX_SNOOZE(3)
`ifdef ALARM_TIMEOUT_EN
    ,
    .RING_TIMEOUT(4)
`endif
  ) dut (
    .clk(clk), .rst(rst), .tick_1hz(tick_1hz),
    .HT(HT), .HU(HU), .MT(MT), .MU(MU),
    .HT_al(HT_al), .HU_al(HU_al), .MT_al(MT_al), .MU_al(MU_al),
    .arm(arm), .snooze(snooze), .stop(stop),
    .ring_led(ring_led), .ringing(ringing), .snoozing(snoozing),
    .snooze_cnt(snooze_cnt), .state(state)
  );

  always #5 clk = ~clk;

  // One clock cycle: pulses are applied for exactly the next edge, then cleared.
  task automatic cyc(input logic t, input logic sn, input logic sp);
    tick_1hz = t;
    snooze   = sn;
    stop     = sp;
    @(posedge clk);
    #1;
    tick_1hz = 1'b0;
    snooze   = 1'b0;
    stop     = 1'b0;
  endtask

  task automatic set_time(input logic [3:0] ht, input logic [3:0] hu,
                          input logic [3:0] mt, input logic [3:0] mu);
    HT = ht; HU = hu; MT = mt; MU = mu;
  endtask

  task automatic set_alarm(input logic [3:0] ht, input logic [3:0] hu,
                           input logic [3:0] mt, input logic [3:0] mu);
    HT_al = ht; HU_al = hu; MT_al = mt; MU_al = mu;
  endtask

  task automatic expect_out(input string nm, input logic [2:0] st, input logic rg,
                            input logic sz, input logic led, input logic [3:0] cnt);
    exp_q.push_back({st, rg, sz, led, cnt});
    name_q.push_back(nm);
  endtask

  always @(negedge clk) begin
    logic [9:0] e;
    logic [9:0] a;
    string      nm;
    while (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a  = {state, ringing, snoozing, ring_led, snooze_cnt};
      n_cmp++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL %s: got st=%0d rg=%b sz=%b led=%b cnt=%0d, expected st=%0d rg=%b sz=%b led=%b cnt=%0d",
                 nm, a[9:7], a[6], a[5], a[4], a[3:0], e[9:7], e[6], e[5], e[4], e[3:0]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected bench to finish");
    n_fail++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    // Reset and first ring at 07:30
    arm = 1'b1;
    set_alarm(4'd0, 4'd7, 4'd3, 4'd0);
    set_time(4'd0, 4'd7, 4'd2, 4'd9);
    repeat (3) cyc(0, 0, 0);
    expect_out("reset", 3'd0, 0, 0, 0, 4'd0);
    rst = 1'b1;
    repeat (3) cyc(0, 0, 0);
    expect_out("idle_0729", 3'd0, 0, 0, 0, 4'd0);
    set_time(4'd0, 4'd7, 4'd3, 4'd0);
    cyc(0, 0, 0);
    expect_out("rise_latency", 3'd0, 0, 0, 0, 4'd0);
    cyc(0, 0, 0);
    expect_out("ring_entry", 3'd1, 1, 0, 1, 4'd0);
    cyc(1, 0, 0);
    expect_out("blink_tick1", 3'd1, 1, 0, 0, 4'd0);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    expect_out("blink_hold", 3'd1, 1, 0, 0, 4'd0);
    cyc(1, 0, 0);
    expect_out("blink_tick2", 3'd1, 1, 0, 1, 4'd0);

    // Snooze three times, each re-ring after 5 ticks; fourth snooze dismisses
    cyc(0, 1, 0);
    expect_out("snooze1", 3'd2, 0, 1, 0, 4'd1);
    for (int i = 0; i < 4; i++) begin
      cyc(1, 0, 0);
      cyc(0, 0, 0);
    end
    expect_out("snooze1_4ticks", 3'd2, 0, 1, 0, 4'd1);
    cyc(1, 0, 0);
    expect_out("rering1", 3'd1, 1, 0, 1, 4'd1);
    cyc(0, 1, 0);
    expect_out("snooze2", 3'd2, 0, 1, 0, 4'd2);
    repeat (5) cyc(1, 0, 0);
    expect_out("rering2", 3'd1, 1, 0, 1, 4'd2);
    cyc(0, 1, 0);
    expect_out("snooze3", 3'd2, 0, 1, 0, 4'd3);
    repeat (5) cyc(1, 0, 0);
    expect_out("rering3", 3'd1, 1, 0, 1, 4'd3);
    cyc(0, 1, 0);
    expect_out("snooze4_done", 3'd3, 0, 0, 0, 4'd3);
    repeat (5) cyc(1, 0, 0);
    expect_out("done_hold_0730", 3'd3, 0, 0, 0, 4'd3);
    set_time(4'd0, 4'd7, 4'd3, 4'd1);
    cyc(0, 0, 0);
    expect_out("idle_0731", 3'd0, 0, 0, 0, 4'd3);

    // Alarm edit clears count; stop+snooze priority; stop beats tick in SNOOZE
    set_alarm(4'd0, 4'd8, 4'd0, 4'd0);
    set_time(4'd0, 4'd7, 4'd5, 4'd9);
    cyc(0, 0, 0);
    expect_out("edit_clears_cnt", 3'd0, 0, 0, 0, 4'd0);
    set_time(4'd0, 4'd8, 4'd0, 4'd0);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    expect_out("ring_0800", 3'd1, 1, 0, 1, 4'd0);
    cyc(0, 1, 0);
    repeat (5) cyc(1, 0, 0);
    expect_out("rering_0800", 3'd1, 1, 0, 1, 4'd1);
    cyc(0, 1, 1);
    expect_out("stop_snooze_same", 3'd3, 0, 0, 0, 4'd1);
    arm = 1'b0;
    cyc(0, 0, 0);
    expect_out("arm_off", 3'd0, 0, 0, 0, 4'd0);
    arm = 1'b1;
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    expect_out("rearm_ring", 3'd1, 1, 0, 1, 4'd0);
    cyc(1, 1, 0);
    expect_out("snooze_with_tick", 3'd2, 0, 1, 0, 4'd1);
    repeat (4) cyc(1, 0, 0);
    expect_out("snz_4ticks", 3'd2, 0, 1, 0, 4'd1);
    cyc(1, 0, 1);
    expect_out("stop_beats_tick", 3'd3, 0, 0, 0, 4'd1);
    set_time(4'd0, 4'd8, 4'd0, 4'd1);
    cyc(0, 0, 0);
    expect_out("idle_0801", 3'd0, 0, 0, 0, 4'd1);

    // Alarm 00:00 is disabled even when the time matches
    set_alarm(4'd0, 4'd0, 4'd0, 4'd0);
    set_time(4'd0, 4'd0, 4'd0, 4'd0);
    for (int i = 0; i < 6; i++) begin
      cyc(logic'(i % 2), 0, 0);
      expect_out("alarm_0000", 3'd0, 0, 0, 0, 4'd0);
    end

    // Reset in the middle of SNOOZE leaves nothing pending
    set_alarm(4'd1, 4'd0, 4'd0, 4'd0);
    set_time(4'd0, 4'd9, 4'd5, 4'd9);
    cyc(0, 0, 0);
    set_time(4'd1, 4'd0, 4'd0, 4'd0);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    expect_out("ring_1000", 3'd1, 1, 0, 1, 4'd0);
    cyc(0, 1, 0);
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    expect_out("snooze_1000", 3'd2, 0, 1, 0, 4'd1);
    rst = 1'b0;
    set_time(4'd1, 4'd0, 4'd0, 4'd1);
    cyc(0, 0, 0);
    expect_out("rst_mid_snooze", 3'd0, 0, 0, 0, 4'd0);
    rst = 1'b1;
    repeat (8) cyc(1, 0, 0);
    expect_out("no_rering_after_rst", 3'd0, 0, 0, 0, 4'd0);

`ifdef ALARM_TIMEOUT_EN
    // Auto-dismiss on the fourth tick of continuous ringing
    set_alarm(4'd1, 4'd1, 4'd0, 4'd0);
    set_time(4'd1, 4'd0, 4'd5, 4'd9);
    cyc(0, 0, 0);
    set_time(4'd1, 4'd1, 4'd0, 4'd0);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    expect_out("ring_1100", 3'd1, 1, 0, 1, 4'd0);
    repeat (3) cyc(1, 0, 0);
    expect_out("timeout_3ticks", 3'd1, 1, 0, 0, 4'd0);
    cyc(1, 0, 0);
    expect_out("timeout_done", 3'd3, 0, 0, 0, 4'd0);
`endif

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/alarm_ring_sched.md
Name: alarm_ring_sched

Overview:
- Sequences the alarm event for the digital clock.
- Watches the running time and stored alarm time (BCD digits HT:HU:MT:MU) and runs the ring / snooze / dismiss state machine.
- Drives the alarm LED blink and status flags.
- Sits between the clock and alarm-setting datapaths and the LED/display outputs, replacing ad-hoc ring comparison logic.

Parameters:
- SNOOZE_SEC, 300, seconds spent in SNOOZE before re-ringing; range 1..1023.
- MAX_SNOOZE, 3, snooze presses honoured per alarm event; range 0..15.
- RING_TIMEOUT, 60, seconds of continuous ringing before auto-dismiss; used only with ALARM_TIMEOUT_EN.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-low reset (reset when rst==0 at posedge clk)
- tick_1hz  in  1  one-cycle pulse per second from clock divider
- HT, HU, MT, MU  in  4 each  current time digits, BCD
- HT_al, HU_al, MT_al, MU_al  in  4 each  alarm time digits, BCD
- arm  in  1  1 = clock mode, alarm active; 0 = alarm-adjust mode
- snooze  in  1  one-cycle pulse (debounced U|D|L|R)
- stop  in  1  one-cycle pulse (debounced C)
- ring_led  out  1  blinking alarm LED
- ringing  out  1  high in RING
- snoozing  out  1  high in SNOOZE
- snooze_cnt  out  4  snoozes used in current event
- state  out  3  encoded FSM state for debug

Behaviour:
- Reset (rst==0 at posedge): state=IDLE, all outputs 0, all timers 0, match_d=0.
- match = arm AND (current digits == alarm digits) AND (alarm != 00:00). Alarm 00:00 means disabled.
- match_d is match registered one cycle. rise = match AND NOT match_d.
- States: IDLE=0, RING=1, SNOOZE=2, DONE=3. Other encodes recover to IDLE next cycle.
- IDLE: on rise -> RING. RING is entered on the edge after rise is sampled (1-cycle latency). Entry clears snooze_cnt, sec_cnt and the blink phase.
- RING:
  - ringing=1.
  - ring_led=1 on the first cycle, then toggles on each tick_1hz.
  - stop -> DONE.
  - snooze with snooze_cnt < MAX_SNOOZE -> SNOOZE, snooze_cnt+1, sec_cnt=0.
  - snooze with snooze_cnt == MAX_SNOOZE -> DONE (same as stop).
- SNOOZE:
  - snoozing=1, ring_led=0.
  - sec_cnt increments on tick_1hz.
  - When a tick arrives with sec_cnt==SNOOZE_SEC-1 -> RING; re-ring does not require match.
  - stop -> DONE. snooze is ignored.
- DONE:
  - Outputs 0. Holds until match==0, then -> IDLE.
  - Prevents re-trigger within the same alarm minute.
- Priority:
  - arm==0, or any alarm digit changing versus its registered copy, forces IDLE from any state and clears snooze_cnt.
  - Next priority is stop, then snooze, then tick.
- Simultaneous events:
  - stop+snooze in the same cycle: stop wins.
  - Button and tick in the same cycle: the button transition is taken; the tick is discarded.
- sec_cnt width is 10 bits; it saturates, never wraps.
- snooze_cnt never exceeds MAX_SNOOZE.
- When the clock wraps 23:59 -> 00:00, only the digit comparison matters; there is no special casing.
- Reset asserted mid-RING or mid-SNOOZE: outputs 0 on the next edge and no pending re-ring survives.

Optional Feature:
- Macro: ALARM_TIMEOUT_EN.
- Defined:
  - RING counts tick_1hz in sec_cnt.
  - When a tick arrives with sec_cnt==RING_TIMEOUT-1 -> DONE (auto-dismiss).
  - Each re-entry to RING restarts the count at 0.
- Undefined: RING persists until stop, snooze, arm==0 or an alarm edit. No timeout logic is synthesised.

Test Plan:
- Alarm 07:30, arm=1, time steps 07:29 -> 07:30 -> ringing=1 two cycles after digits change; ring_led=1, then toggles each tick; state=1.
- Ringing; snooze pulse with SNOOZE_SEC=5 -> snoozing=1 and snooze_cnt=1; after 5 ticks -> ringing=1 again while time is still 07:30 or later.
- MAX_SNOOZE=3; four snooze presses across re-rings -> the fourth goes to DONE; snooze_cnt=3; no re-ring in minute 07:30; IDLE once time reads 07:31.
- stop and snooze in the same cycle while ringing -> DONE; snooze_cnt unchanged; ringing=0 next cycle.
- Alarm set to 00:00 with time 00:00, arm=1 -> stays IDLE; ring_led=0 throughout.
- ALARM_TIMEOUT_EN, RING_TIMEOUT=4: ring with no buttons -> DONE after 4th tick. Second run: rst=0 driven mid-SNOOZE -> all outputs 0 on next edge, state=0.
